// File: rtl/gfx_scan_timing_if.sv
// Timing and framebuffer-sequencer bus between graphics_top and gfx_scan_timing.
// Names carry the direction seen from the timing generator.
interface gfx_scan_timing_if #(
   parameter int HC_W   = 9,
   parameter int VC_W   = 8,
   parameter int ADDR_W = 17
);
   logic              i_enable;
   logic [VC_W-1:0]   i_vcount_target;
   logic              i_swap_req;
   logic              o_pixel_step;
   logic [HC_W-1:0]   o_hcount;
   logic [VC_W-1:0]   o_vcount;
   logic              o_wen;
   logic [ADDR_W-1:0] o_fb_addr;
   logic              o_hblank;
   logic              o_vblank;
   logic              o_vcount_match;
   logic              o_hblank_start;
   logic              o_vblank_start;
   logic              o_frame_start;
   logic              o_swap_pending;
   logic              o_swap_ack;
   logic              o_front_buf;

   modport master (
      output i_enable, i_vcount_target, i_swap_req,
      input  o_pixel_step, o_hcount, o_vcount, o_wen, o_fb_addr, o_hblank, o_vblank,
             o_vcount_match, o_hblank_start, o_vblank_start, o_frame_start,
             o_swap_pending, o_swap_ack, o_front_buf
   );

   modport slave (
      input  i_enable, i_vcount_target, i_swap_req,
      output o_pixel_step, o_hcount, o_vcount, o_wen, o_fb_addr, o_hblank, o_vblank,
             o_vcount_match, o_hblank_start, o_vblank_start, o_frame_start,
             o_swap_pending, o_swap_ack, o_front_buf
   );
endinterface

// File: rtl/gfx_scan_timing.sv
// Scanline/frame timing generator with framebuffer write addressing and a
// double-buffer swap that is only ever applied at vblank entry.
//
// Swap FSM states:
//   state     | meaning
//   S_IDLE    | no swap request outstanding
//   S_PENDING | request latched, waiting for the next vblank entry
module gfx_scan_timing #(
   parameter int H_ACTIVE = 240,
   parameter int H_TOTAL  = 308,
   parameter int V_ACTIVE = 160,
   parameter int V_TOTAL  = 228,
   parameter int DIV      = 4,
   parameter int HC_W     = 9,
   parameter int VC_W     = 8,
   parameter int ADDR_W   = 17
) (
   input logic         i_clock,
   input logic         i_reset,
   gfx_scan_timing_if.slave bus
);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0]  H_ACT    = HC_W'(H_ACTIVE);
   localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0]  V_ACT    = VC_W'(V_ACTIVE);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } swap_state_t;

   swap_state_t       r_state;
   swap_state_t       w_state_nxt;
   logic [DIV_W-1:0]  r_div;
   logic [HC_W-1:0]   r_hcount;
   logic [VC_W-1:0]   r_vcount;
   logic [ADDR_W-1:0] r_fb_addr;
   logic              r_hblank_start;
   logic              r_vblank_start;
   logic              r_frame_start;
   logic              r_swap_ack;
   logic              r_front_buf;

   logic              w_pixel_step;
   logic              w_h_last;
   logic              w_v_last;
   logic [HC_W-1:0]   w_hc_nxt;
   logic [VC_W-1:0]   w_vc_nxt;
   logic              w_wen;
   logic              w_frame_wrap;
   logic              w_vb_entry;
   logic              w_apply;

   assign w_pixel_step = bus.i_enable && (r_div == DIV_LAST);
   assign w_h_last     = (r_hcount == H_LAST);
   assign w_v_last     = (r_vcount == V_LAST);
   assign w_hc_nxt     = w_h_last ? '0 : r_hcount + 1'b1;
   assign w_vc_nxt     = !w_h_last ? r_vcount : (w_v_last ? '0 : r_vcount + 1'b1);
   assign w_wen        = (r_hcount < H_ACT) && (r_vcount < V_ACT);
   assign w_frame_wrap = w_pixel_step && w_h_last && w_v_last;
   // Qualified by pixel_step, so this is exactly the clock that raises vblank_start.
   assign w_vb_entry   = w_pixel_step && w_h_last && (w_vc_nxt == V_ACT);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_div          <= '0;
         r_hcount       <= '0;
         r_vcount       <= '0;
         r_fb_addr      <= '0;
         r_hblank_start <= 1'b0;
         r_vblank_start <= 1'b0;
         r_frame_start  <= 1'b0;
      end else begin
         if (bus.i_enable) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
         end
         if (w_pixel_step) begin
            r_hcount <= w_hc_nxt;
            r_vcount <= w_vc_nxt;
            if (w_frame_wrap) begin
               r_fb_addr <= '0;
            end else if (w_wen) begin
               r_fb_addr <= r_fb_addr + 1'b1;
            end
         end
         r_hblank_start <= w_pixel_step && (w_hc_nxt == H_ACT);
         r_vblank_start <= w_vb_entry;
         r_frame_start  <= w_frame_wrap;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_swap_ack  <= 1'b0;
         r_front_buf <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_swap_ack <= w_apply;
         if (w_apply) begin
            r_front_buf <= ~r_front_buf;
         end
      end
   end

   // A request arriving on the vblank-entry clock is applied at once, never deferred a frame.
   always_comb begin
      w_state_nxt = r_state;
      w_apply     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_swap_req && w_vb_entry) begin
               w_apply = 1'b1;
            end else if (bus.i_swap_req) begin
               w_state_nxt = S_PENDING;
            end
         end
         S_PENDING: begin
            if (w_vb_entry) begin
               w_apply     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.o_pixel_step   = w_pixel_step;
   assign bus.o_hcount       = r_hcount;
   assign bus.o_vcount       = r_vcount;
   assign bus.o_wen          = w_wen;
   assign bus.o_fb_addr      = r_fb_addr;
   assign bus.o_hblank       = (r_hcount >= H_ACT);
   assign bus.o_vblank       = (r_vcount >= V_ACT);
   assign bus.o_vcount_match = (r_vcount == bus.i_vcount_target);
   assign bus.o_hblank_start = r_hblank_start;
   assign bus.o_vblank_start = r_vblank_start;
   assign bus.o_frame_start  = r_frame_start;
   assign bus.o_swap_pending = (r_state == S_PENDING);
   assign bus.o_swap_ack     = r_swap_ack;
   assign bus.o_front_buf    = r_front_buf;
endmodule

// File: tb/tb_gfx_scan_timing.sv
// Bench for gfx_scan_timing: default geometry for line timing, a reduced
// geometry for frame/swap behaviour, and a tiny DIV=1 geometry driven from a vector table.
module tb_gfx_scan_timing;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d, rst_m, rst_s;
   int   n_checks = 0;
   int   n_errors = 0;

   gfx_scan_timing_if #(.HC_W(9), .VC_W(8), .ADDR_W(17)) if_d ();
   gfx_scan_timing_if #(.HC_W(4), .VC_W(4), .ADDR_W(6))  if_m ();
   gfx_scan_timing_if #(.HC_W(3), .VC_W(2), .ADDR_W(4))  if_s ();

   gfx_scan_timing u_def (.i_clock(clk), .i_reset(rst_d), .bus(if_d));

   gfx_scan_timing #(
      .H_ACTIVE(8), .H_TOTAL(12), .V_ACTIVE(6), .V_TOTAL(9), .DIV(4),
      .HC_W(4), .VC_W(4), .ADDR_W(6)
   ) u_mid (.i_clock(clk), .i_reset(rst_m), .bus(if_m));

   gfx_scan_timing #(
      .H_ACTIVE(4), .H_TOTAL(6), .V_ACTIVE(2), .V_TOTAL(3), .DIV(1),
      .HC_W(3), .VC_W(2), .ADDR_W(4)
   ) u_small (.i_clock(clk), .i_reset(rst_s), .bus(if_s));

   typedef struct {
      int en, tgt, h, v, a, wen, hb, vb, vm, hbs, vbs, fs, ps;
   } vec_t;
   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addv(input int en, tgt, h, v, a, wen, hb, vb, vm, hbs, vbs, fs, ps);
      vec_t r;
      r = '{en, tgt, h, v, a, wen, hb, vb, vm, hbs, vbs, fs, ps};
      vq.push_back(r);
   endtask

   task automatic wait_mid_line(input int line);
      int k = 0;
      while (int'(if_m.o_vcount) != line && k < 1000) begin
         tick();
         k++;
      end
      check($sformatf("mid_reach_line%0d", line), 32'(if_m.o_vcount), 32'(line));
   endtask

   task automatic pulse_mid_swap();
      if_m.i_swap_req = 1'b1;
      tick();
      if_m.i_swap_req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, first, second, bad, acks, per, hbs_n, vbs_n, fb47, rises;
      logic prev;
      logic [31:0] act, exp;

      if_d.i_enable = 1'b1; if_d.i_vcount_target = '0; if_d.i_swap_req = 1'b0;
      if_m.i_enable = 1'b1; if_m.i_vcount_target = '0; if_m.i_swap_req = 1'b0;
      if_s.i_enable = 1'b1; if_s.i_vcount_target = 2'd1; if_s.i_swap_req = 1'b0;
      rst_d = 1'b1; rst_m = 1'b1; rst_s = 1'b1;
      repeat (3) tick();

      // ---------------- default geometry: line timing ----------------
      rst_d = 1'b0;
      #1;
      check("def_reset_counts", {if_d.o_hcount, if_d.o_vcount, if_d.o_fb_addr}, 32'd0);
      check("def_reset_flags", {if_d.o_wen, if_d.o_hblank, if_d.o_vblank, if_d.o_pixel_step}, 32'b1000);
      check("def_reset_strobes", {if_d.o_hblank_start, if_d.o_vblank_start, if_d.o_frame_start,
                                  if_d.o_swap_pending, if_d.o_swap_ack, if_d.o_front_buf}, 32'd0);
      first = -1; second = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (if_d.o_pixel_step) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
      end
      n = 12;
      check("def_first_pixel_step", 32'(first), 32'd3);
      check("def_pixel_step_period", 32'(second - first), 32'd4);
      check("def_hcount_after12", 32'(if_d.o_hcount), 32'd3);

      while (if_d.o_hcount != 9'd239 && n < 2000) begin tick(); n++; end
      check("def_fb_at_h239", 32'(if_d.o_fb_addr), 32'd239);
      while (if_d.o_hcount != 9'd240 && n < 2000) begin tick(); n++; end
      check("def_hblank_start_at_240", {if_d.o_hblank_start, if_d.o_hblank, if_d.o_wen}, 32'b110);
      check("def_fb_at_h240", 32'(if_d.o_fb_addr), 32'd240);
      bad = 0;
      while (if_d.o_hcount != 9'd0 && n < 3000) begin
         tick(); n++;
         if (if_d.o_fb_addr != 17'd240) bad++;
      end
      check("def_fb_hold_hblank", 32'(bad), 32'd0);
      check("def_line_wrap_clocks", 32'(n), 32'd1232);
      check("def_vcount_line1", 32'(if_d.o_vcount), 32'd1);
      if_d.i_vcount_target = 8'd1;
      #1;
      check("def_vmatch_hit", 32'(if_d.o_vcount_match), 32'd1);
      if_d.i_vcount_target = 8'd0;
      #1;
      check("def_vmatch_miss", 32'(if_d.o_vcount_match), 32'd0);

      while (if_d.o_hcount != 9'd50 && n < 3000) begin tick(); n++; end
      check("def_fb_before_pause", 32'(if_d.o_fb_addr), 32'd290);
      if_d.i_enable = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (if_d.o_hcount != 9'd50 || if_d.o_vcount != 8'd1 || if_d.o_fb_addr != 17'd290 ||
             if_d.o_pixel_step || if_d.o_hblank_start || if_d.o_vblank_start || if_d.o_frame_start)
            bad++;
      end
      check("def_pause_frozen", 32'(bad), 32'd0);
      if_d.i_enable = 1'b1;
      repeat (3) tick();
      check("def_resume_step_phase", {if_d.o_pixel_step, 23'd0, if_d.o_hcount}, {1'b1, 23'd0, 9'd50});
      tick();
      check("def_resume_advance", {if_d.o_hcount, if_d.o_fb_addr}, {9'd51, 17'd291});

      // ---------------- reduced geometry: frame and swap ----------------
      rst_m = 1'b0;
      wait_mid_line(2);
      pulse_mid_swap();
      check("mid_pending_after_req", {if_m.o_swap_pending, if_m.o_front_buf}, 32'b10);
      wait_mid_line(4);
      pulse_mid_swap();
      check("mid_second_req_absorbed", {if_m.o_swap_pending, if_m.o_front_buf, if_m.o_swap_ack}, 32'b100);
      n = 0;
      while (!if_m.o_vblank_start && n < 600) begin tick(); n++; end
      check("mid_vbs_position", {if_m.o_vcount, if_m.o_hcount, 3'd0, if_m.o_vblank}, {4'd6, 4'd0, 3'd0, 1'b1});
      check("mid_swap_applied", {if_m.o_swap_ack, if_m.o_front_buf, if_m.o_swap_pending}, 32'b110);
      acks = 0; n = 0;
      while (!if_m.o_frame_start && n < 600) begin
         tick(); n++;
         if (if_m.o_swap_ack) acks++;
      end
      check("mid_no_extra_ack", 32'(acks), 32'd0);
      check("mid_fb_zero_on_frame_start", 32'(if_m.o_fb_addr), 32'd0);

      per = 0; hbs_n = 0; vbs_n = 0; fb47 = -1; bad = 0;
      do begin
         tick(); per++;
         if (if_m.o_hblank_start) begin
            hbs_n++;
            if (if_m.o_hcount != 4'd8) bad++;
         end
         if (if_m.o_vblank_start) vbs_n++;
         if (if_m.o_hcount == 4'd7 && if_m.o_vcount == 4'd5) fb47 = int'(if_m.o_fb_addr);
         if (if_m.o_vblank && if_m.o_fb_addr != 6'd48) bad++;
      end while (!if_m.o_frame_start && per < 1000);
      check("mid_frame_period", 32'(per), 32'd432);
      check("mid_hblank_start_count", 32'(hbs_n), 32'd9);
      check("mid_vblank_start_count", 32'(vbs_n), 32'd1);
      check("mid_fb_last_visible", 32'(fb47), 32'd47);
      check("mid_fb_hold_and_hbs_pos", 32'(bad), 32'd0);
      check("mid_fb_wrap", 32'(if_m.o_fb_addr), 32'd0);

      wait_mid_line(3);
      pulse_mid_swap();
      check("mid_pending_before_reset", {if_m.o_swap_pending, if_m.o_front_buf}, 32'b11);
      rst_m = 1'b1;
      tick();
      check("mid_reset_counts", {if_m.o_hcount, if_m.o_vcount, if_m.o_fb_addr}, 32'd0);
      check("mid_reset_swap", {if_m.o_swap_pending, if_m.o_swap_ack, if_m.o_front_buf,
                               if_m.o_hblank_start, if_m.o_vblank_start, if_m.o_frame_start}, 32'd0);
      rst_m = 1'b0;
      acks = 0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (if_m.o_swap_ack) acks++;
      end
      check("mid_reset_discards_swap", {28'(acks), 3'd0, if_m.o_front_buf}, 32'd0);

      n = 0;
      while (!(if_m.o_vcount == 4'd5 && if_m.o_hcount == 4'd11 && if_m.o_pixel_step) && n < 1000) begin
         tick(); n++;
      end
      check("mid_reach_pre_vblank", {if_m.o_vcount, if_m.o_hcount}, {4'd5, 4'd11});
      pulse_mid_swap();
      check("mid_coincident_swap", {if_m.o_vblank_start, if_m.o_swap_ack, if_m.o_front_buf, if_m.o_swap_pending},
            32'b1110);
      tick();
      check("mid_ack_single_cycle", {if_m.o_swap_ack, if_m.o_front_buf}, 32'b01);

      if_m.i_swap_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 900; i++) begin
         tick();
         if (if_m.o_swap_ack) acks++;
      end
      if_m.i_swap_req = 1'b0;
      check("mid_level_req_one_per_frame", 32'(acks), 32'd2);
      check("mid_level_req_front", 32'(if_m.o_front_buf), 32'd1);

      // ---------------- tiny geometry, DIV=1: vector table ----------------
      rst_s = 1'b0;
      #1;
      check("small_reset_comb", {if_s.o_pixel_step, if_s.o_wen, if_s.o_hblank, if_s.o_vblank}, 32'b1100);
      //   en tgt h v a  wen hb vb vm hbs vbs fs ps
      addv(1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
      addv(1, 1, 2, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1);
      addv(1, 1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1);
      addv(1, 1, 4, 0, 4, 0, 1, 0, 0, 1, 0, 0, 1);
      addv(0, 1, 4, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 4, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0);
      addv(1, 1, 5, 0, 4, 0, 1, 0, 0, 0, 0, 0, 1);
      addv(1, 1, 0, 1, 4, 1, 0, 0, 1, 0, 0, 0, 1);
      addv(1, 1, 1, 1, 5, 1, 0, 0, 1, 0, 0, 0, 1);
      addv(1, 1, 2, 1, 6, 1, 0, 0, 1, 0, 0, 0, 1);
      addv(1, 1, 3, 1, 7, 1, 0, 0, 1, 0, 0, 0, 1);
      addv(1, 1, 4, 1, 8, 0, 1, 0, 1, 1, 0, 0, 1);
      addv(1, 1, 5, 1, 8, 0, 1, 0, 1, 0, 0, 0, 1);
      addv(1, 1, 0, 2, 8, 0, 0, 1, 0, 0, 1, 0, 1);
      addv(1, 1, 1, 2, 8, 0, 0, 1, 0, 0, 0, 0, 1);
      addv(1, 1, 2, 2, 8, 0, 0, 1, 0, 0, 0, 0, 1);
      addv(1, 1, 3, 2, 8, 0, 0, 1, 0, 0, 0, 0, 1);
      addv(1, 1, 4, 2, 8, 0, 1, 1, 0, 1, 0, 0, 1);
      addv(1, 1, 5, 2, 8, 0, 1, 1, 0, 0, 0, 0, 1);
      addv(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
      addv(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
      foreach (vq[i]) begin
         if_s.i_enable        = vq[i].en[0];
         if_s.i_vcount_target = vq[i].tgt[1:0];
         tick();
         act = {15'd0, if_s.o_hcount, if_s.o_vcount, if_s.o_fb_addr,
                if_s.o_wen, if_s.o_hblank, if_s.o_vblank, if_s.o_vcount_match,
                if_s.o_hblank_start, if_s.o_vblank_start, if_s.o_frame_start, if_s.o_pixel_step};
         exp = {15'd0, vq[i].h[2:0], vq[i].v[1:0], vq[i].a[3:0],
                vq[i].wen[0], vq[i].hb[0], vq[i].vb[0], vq[i].vm[0],
                vq[i].hbs[0], vq[i].vbs[0], vq[i].fs[0], vq[i].ps[0]};
         check($sformatf("small_vec%0d", i), act, exp);
      end

      if_s.i_enable = 1'b1;
      if_s.i_vcount_target = 2'd1;
      #1;
      n = 0; rises = 0; prev = if_s.o_vcount_match;
      for (int i = 0; i < 18; i++) begin
         tick();
         if (if_s.o_vcount_match) n++;
         if (if_s.o_vcount_match && !prev) rises++;
         prev = if_s.o_vcount_match;
      end
      check("small_vmatch_clocks", 32'(n), 32'd6);
      check("small_vmatch_one_window", 32'(rises), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/gfx_scan_timing.md
Name: gfx_scan_timing

Overview:
- Parametrised scanline/frame timing generator and framebuffer write sequencer for the graphics path.
- Produces the pixel step, hcount/vcount, blanking flags and a linear framebuffer write address for the graphics pipeline.
- Adds what the previous fixed-geometry driver lacked: a vcount-match output, event strobes, and a request/acknowledge buffer swap that is applied only at vblank entry.
- Sits between graphics_top (consumer of counts/strobes) and the double-buffer RAMs (consumer of fb_addr/wen/front_buf).

Parameters:
- H_ACTIVE, 240, visible pixels per line.
- H_TOTAL, 308, total pixel slots per line including hblank; must be > H_ACTIVE.
- V_ACTIVE, 160, visible lines per frame.
- V_TOTAL, 228, total lines per frame; must be > V_ACTIVE.
- DIV, 4, clock cycles per pixel slot; must be >= 1.
- HC_W, 9, hcount width; must satisfy 2^HC_W >= H_TOTAL.
- VC_W, 8, vcount width; must satisfy 2^VC_W >= V_TOTAL.
- ADDR_W, 17, fb_addr width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, all counters and the divider hold, and strobes are suppressed.
- vcount_target  in  VC_W  line compared against vcount.
- swap_req  in  1  single-cycle or level request to swap buffers at the next vblank entry.
- pixel_step  out  1  high on the last divider cycle of each pixel slot.
- hcount  out  HC_W  current pixel slot, 0..H_TOTAL-1.
- vcount  out  VC_W  current line, 0..V_TOTAL-1.
- wen  out  1  current slot is visible.
- fb_addr  out  ADDR_W  linear write address of the current visible pixel.
- hblank  out  1  hcount >= H_ACTIVE.
- vblank  out  1  vcount >= V_ACTIVE.
- vcount_match  out  1  vcount == vcount_target.
- hblank_start  out  1  one-cycle strobe on hblank entry.
- vblank_start  out  1  one-cycle strobe on vblank entry.
- frame_start  out  1  one-cycle strobe on wrap to line 0.
- swap_pending  out  1  a swap request is latched and not yet applied.
- swap_ack  out  1  one-cycle strobe when the swap is applied.
- front_buf  out  1  index of the buffer being displayed; the graphics side writes to ~front_buf.

Behaviour:
- Reset values: divider, hcount, vcount, fb_addr, front_buf, swap_pending and all strobes are 0.
- Combinational outputs follow the reset state: wen=1, hblank=0, vblank=0, pixel_step=1 when DIV=1 and enable=1.
- Divider: counts 0..DIV-1 while enable=1 and wraps to 0. pixel_step = enable && (div == DIV-1).
- On pixel_step:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0.
- fb_addr:
  - Increments on pixel_step when wen=1.
  - Cleared to 0 on the pixel_step that wraps the frame.
  - The clear has priority over the increment.
  - Max value is H_ACTIVE*V_ACTIVE-1; no other wrap exists.
- Combinational outputs decoded from the registered counters: wen, hblank, vblank, vcount_match.
- Strobes are registered and assert for exactly one clock, in the same cycle the counters show the new value:
  - hblank_start when hcount becomes H_ACTIVE.
  - vblank_start when vcount becomes V_ACTIVE (hcount = 0).
  - frame_start when vcount and hcount both become 0.
- Swap state machine, two states, IDLE/PENDING (swap_pending = PENDING):
  - IDLE -> PENDING on swap_req=1.
  - PENDING -> IDLE on the clock that raises vblank_start; in that clock front_buf toggles and swap_ack pulses.
  - If swap_req is high in the same clock as the vblank-entry update, that swap is applied immediately (toggle + ack) from either state.
  - Further swap_req while PENDING is absorbed: one toggle per vblank maximum.
  - swap_req held high continuously produces one swap per frame.
- enable=0:
  - Divider, counters and fb_addr hold; strobes are 0.
  - The swap FSM still latches requests but cannot apply them until vblank entry occurs.
- Reset mid-frame returns everything to the reset values on the next clock and discards any pending swap.
- DIV=1: pixel_step is constantly high while enabled.

Test Plan:
- Defaults, enable=1 from reset:
  - pixel_step every 4 clocks.
  - hcount wraps 307->0 every 1232 clocks.
  - frame_start period is 280896 clocks.
  - vcount sequence 0..227.
- fb_addr:
  - Equals 239 at (h=239, v=0); holds at 240 through hblank.
  - Equals 38399 at (h=239, v=159); remains 38400 through vblank.
  - Returns to 0 with frame_start.
- vblank_start:
  - Single pulse with vcount=160, hcount=0, vblank rising the same cycle.
  - hblank_start pulses 228 times per frame with hcount=240.
- Swap:
  - swap_req pulse at line 50: swap_pending=1 until vblank entry, then front_buf 0->1 and swap_ack pulses once.
  - A second pulse at line 100 of the same frame causes no extra toggle.
  - A swap_req coincident with vblank entry toggles in that clock.
- enable and reset:
  - enable low for 100 clocks mid-line: counters frozen, no strobes; timing resumes exactly where it paused.
  - Reset at line 120 with a swap pending: all outputs 0, pending cleared, no swap_ack.
- Non-default parameters and vcount_match:
  - H_ACTIVE=4, H_TOTAL=6, V_ACTIVE=2, V_TOTAL=3, DIV=1: frame = 18 clocks; fb_addr 0..7 then 0.
  - vcount_target=1: vcount_match high for exactly 6 consecutive clocks per frame.
